// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule blocks: round count, Rcon table,
// word/key typedefs and the inverse key-schedule state encoding.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned IDX_W  = 4;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key128_t;

  // Rcon[i] in the top byte of the round-constant word; index 0 unused.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } inv_ks_state_e;

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Load / round-key handshake bundle for aes_inv_key_schedule.
//   load_valid/load_ready/key_in       : cipher key load
//   load_is_last                       : key_in is already the round-10 key
//                                        (only with AES_INV_KEY_PRELOAD_EN)
//   rk_valid/rk_ready/round_key/rk_idx/rk_last : round keys, 10 down to 0
// master = key source / round-key consumer, slave = the key schedule.
interface aes_inv_key_schedule_if;
  import aes_pkg::*;

  logic                load_valid;
  logic                load_ready;
  aes_key128_t         key_in;
`ifdef AES_INV_KEY_PRELOAD_EN
  logic                load_is_last;
`endif
  logic                rk_valid;
  logic                rk_ready;
  aes_key128_t         round_key;
  logic [IDX_W-1:0]    rk_idx;
  logic                rk_last;

`ifdef AES_INV_KEY_PRELOAD_EN
  modport master (
    output load_valid, key_in, load_is_last, rk_ready,
    input  load_ready, rk_valid, round_key, rk_idx, rk_last
  );
  modport slave (
    input  load_valid, key_in, load_is_last, rk_ready,
    output load_ready, rk_valid, round_key, rk_idx, rk_last
  );
`else
  modport master (
    output load_valid, key_in, rk_ready,
    input  load_ready, rk_valid, round_key, rk_idx, rk_last
  );
  modport slave (
    input  load_valid, key_in, rk_ready,
    output load_ready, rk_valid, round_key, rk_idx, rk_last
  );
`endif

endinterface

// File: rtl/aes_key_word_sub.sv
// SubWord(RotWord(w)) for AES key expansion; shared by forward and inverse
// key schedules. Purely combinational.
//   w : 32-bit input word
//   y : rotated and substituted word
module aes_key_word_sub
  import aes_pkg::*;
(
  input  aes_word_t w,
  output aes_word_t y
);

  aes_word_t rot;

  // RotWord: {a0,a1,a2,a3} -> {a1,a2,a3,a0}
  assign rot = {w[23:0], w[31:24]};

  s_box u_sb3 (.a(rot[31:24]), .s(y[31:24]));
  s_box u_sb2 (.a(rot[23:16]), .s(y[23:16]));
  s_box u_sb1 (.a(rot[15:8]),  .s(y[15:8]));
  s_box u_sb0 (.a(rot[7:0]),   .s(y[7:0]));

endmodule

// File: rtl/s_box.sv
// AES forward S-box, one byte, purely combinational lookup.
//   a : input byte
//   s : substituted byte
module s_box (
  input  logic [7:0] a,
  output logic [7:0] s
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign s = SBOX[a];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: takes the cipher key, runs 10 forward
// expansion steps to reach the round-10 key, then hands out round keys
// 10 down to 0, one per accepted rk handshake.
// Optional macro AES_INV_KEY_PRELOAD_EN: adds load_is_last so a round-10 key
// can be loaded directly, skipping the forward pass.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : aes_inv_key_schedule_if.slave (load and round-key handshakes)
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  aes_inv_key_schedule_if.slave bus
);

  inv_ks_state_e     state;
  aes_key128_t       key_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              load_ready_q;
  logic              rk_valid_q;
  logic              rk_last_q;

  aes_word_t   w0, w1, w2, w3;
  aes_word_t   sub_in, sub_out, t;
  logic [7:0]  rcon_sel;
  aes_key128_t fwd_key, inv_key;

  assign {w0, w1, w2, w3} = key_q;

  // Single SubWord unit: w3 feeds it going forward, w3^w2 (the previous
  // round's w3) feeds it going backward.
  always_comb begin
    sub_in   = w3;
    rcon_sel = RCON[cnt_q];
    if (state == EMIT) begin
      sub_in   = w3 ^ w2;
      rcon_sel = RCON[idx_q];
    end
  end

  aes_key_word_sub u_sub (.w(sub_in), .y(sub_out));

  assign t = sub_out ^ {rcon_sel, 24'h0};

  // Forward step: chained XOR from w0 to w3.
  always_comb begin
    fwd_key[127:96] = w0 ^ t;
    fwd_key[95:64]  = w1 ^ fwd_key[127:96];
    fwd_key[63:32]  = w2 ^ fwd_key[95:64];
    fwd_key[31:0]   = w3 ^ fwd_key[63:32];
  end

  // Inverse step: undo the chain from the top, then recover w0.
  always_comb begin
    inv_key[31:0]   = w3 ^ w2;
    inv_key[63:32]  = w2 ^ w1;
    inv_key[95:64]  = w1 ^ w0;
    inv_key[127:96] = w0 ^ t;
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      key_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b1;
      rk_valid_q   <= 1'b0;
      rk_last_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            key_q        <= bus.key_in;
            load_ready_q <= 1'b0;
`ifdef AES_INV_KEY_PRELOAD_EN
            if (bus.load_is_last) begin
              state      <= EMIT;
              idx_q      <= IDX_W'(AES_NR);
              rk_valid_q <= 1'b1;
              rk_last_q  <= 1'b0;
            end else begin
              state <= FWD;
              cnt_q <= IDX_W'(1);
            end
`else
            state <= FWD;
            cnt_q <= IDX_W'(1);
`endif
          end
        end
        FWD: begin
          key_q <= fwd_key;
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(AES_NR)) begin
            state      <= EMIT;
            idx_q      <= IDX_W'(AES_NR);
            rk_valid_q <= 1'b1;
            rk_last_q  <= 1'b0;
          end
        end
        EMIT: begin
          if (bus.rk_ready) begin
            if (idx_q != '0) begin
              key_q     <= inv_key;
              idx_q     <= idx_q - IDX_W'(1);
              rk_last_q <= (idx_q == IDX_W'(1));
            end else begin
              state        <= IDLE;
              rk_valid_q   <= 1'b0;
              rk_last_q    <= 1'b0;
              load_ready_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.round_key  = key_q;
  assign bus.rk_idx     = idx_q;
  assign bus.rk_last    = rk_last_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule. A reference key expansion
// (S-box built from GF(2^8) inversion) fills a scoreboard with the expected
// round-10..0 sequence; a negedge monitor pops and compares every handshake.
module tb_aes_inv_key_schedule;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_inv_key_schedule_if bus();
  aes_inv_key_schedule dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [11];
  logic [127:0] model_rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic init_model();
    logic [7:0] inv, rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    rcon_m[0] = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      rcon_m[i] = rc;
      rc = gmul(rc, 8'h02);
    end
  endtask

  task automatic push_seq(input logic [127:0] k);
    logic [31:0] w3, t, n0, n1, n2, n3;
    logic [127:0] prev;
    exp_t e;
    model_rk[0] = k;
    for (int r = 1; r <= 10; r++) begin
      prev = model_rk[r-1];
      w3 = prev[31:0];
      t = {sbox_m[w3[23:16]], sbox_m[w3[15:8]], sbox_m[w3[7:0]], sbox_m[w3[31:24]]}
          ^ {rcon_m[r], 24'h0};
      n0 = prev[127:96] ^ t;
      n1 = prev[95:64] ^ n0;
      n2 = prev[63:32] ^ n1;
      n3 = w3 ^ n2;
      model_rk[r] = {n0, n1, n2, n3};
    end
    for (int i = 10; i >= 0; i--) begin
      e.key = model_rk[i];
      e.idx = 4'(i);
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.key_in = k;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.rk_valid) && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 400) begin
      miscompares++;
      $display("FAIL %s_drain: %0d keys still expected, required 0", name, sb.size());
    end
  endtask

  // Scoreboard consumer: one compare per accepted round key.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rk_valid && bus.rk_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_extra: got idx=%0d key=%h, required no key", bus.rk_idx, bus.round_key);
        end else begin
          e = sb.pop_front();
          if (bus.round_key !== e.key || bus.rk_idx !== e.idx || bus.rk_last !== (e.idx == 4'd0)) begin
            miscompares++;
            $display("FAIL sb_key: got idx=%0d last=%b key=%h, required idx=%0d last=%b key=%h",
                     bus.rk_idx, bus.rk_last, bus.round_key, e.idx, (e.idx == 4'd0), e.key);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.key_in = '0;
    bus.rk_ready = 1'b0;
`ifdef AES_INV_KEY_PRELOAD_EN
    bus.load_is_last = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_load_ready: got %b, required 1", bus.load_ready); end
    vectors++;
    if (bus.rk_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rk_valid: got %b, required 0", bus.rk_valid); end
    vectors++;
    if (bus.rk_last !== 1'b0) begin miscompares++; $display("FAIL reset_rk_last: got %b, required 0", bus.rk_last); end
    vectors++;
    if (bus.round_key !== 128'h0) begin miscompares++; $display("FAIL reset_round_key: got %h, required 0", bus.round_key); end
    vectors++;
    if (bus.rk_idx !== 4'd0) begin miscompares++; $display("FAIL reset_rk_idx: got %0d, required 0", bus.rk_idx); end
  endtask

  task automatic test_fips();
    int lat = 0;
    int n = 0;
    bus.rk_ready = 1'b1;
    vectors++;
    if (bus.load_ready !== 1'b1) begin miscompares++; $display("FAIL fips_load_ready: got %b, required 1", bus.load_ready); end
    push_seq(FIPS_KEY);
    load_key(FIPS_KEY);
    while (!bus.rk_valid && lat < 30) begin tick(); lat++; end
    vectors++;
    if (lat != 10) begin miscompares++; $display("FAIL fips_latency: got %0d cycles, required 10", lat); end
    vectors++;
    if (bus.round_key !== FIPS_R10 || bus.rk_idx !== 4'd10) begin
      miscompares++; $display("FAIL fips_r10: got idx=%0d key=%h, required idx=10 key=%h", bus.rk_idx, bus.round_key, FIPS_R10);
    end
    while (bus.rk_idx !== 4'd1 && n < 20) begin tick(); n++; end
    vectors++;
    if (bus.round_key !== FIPS_R1 || bus.rk_valid !== 1'b1) begin
      miscompares++; $display("FAIL fips_r1: got valid=%b key=%h, required valid=1 key=%h", bus.rk_valid, bus.round_key, FIPS_R1);
    end
    tick();
    vectors++;
    if (bus.round_key !== FIPS_KEY || bus.rk_idx !== 4'd0 || bus.rk_last !== 1'b1) begin
      miscompares++; $display("FAIL fips_r0: got idx=%0d last=%b key=%h, required idx=0 last=1 key=%h",
                              bus.rk_idx, bus.rk_last, bus.round_key, FIPS_KEY);
    end
    tick();
    vectors++;
    if (bus.rk_valid !== 1'b0 || bus.load_ready !== 1'b1) begin
      miscompares++; $display("FAIL fips_done: got valid=%b load_ready=%b, required 0/1", bus.rk_valid, bus.load_ready);
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL fips_count: got %0d keys unconsumed, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic held;
    logic [127:0] pk;
    logic [3:0] pi;
    logic [127:0] k;
    int n;
    for (int rep = 0; rep < 2; rep++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      bus.rk_ready = 1'b0;
      push_seq(k);
      load_key(k);
      n = 0;
      while ((sb.size() != 0 || bus.rk_valid) && n < 600) begin
        bus.rk_ready = 1'($urandom_range(0, 1));
        held = bus.rk_valid && !bus.rk_ready;
        pk = bus.round_key;
        pi = bus.rk_idx;
        tick();
        n++;
        if (held) begin
          vectors++;
          if (bus.round_key !== pk || bus.rk_idx !== pi || bus.rk_valid !== 1'b1) begin
            miscompares++; $display("FAIL bp_hold: got valid=%b idx=%0d key=%h, required valid=1 idx=%0d key=%h",
                                    bus.rk_valid, bus.rk_idx, bus.round_key, pi, pk);
          end
        end
      end
      vectors++;
      if (n >= 600) begin miscompares++; $display("FAIL bp_timeout: got %0d keys left, required 0", sb.size()); end
    end
  endtask

  task automatic test_load_ignored();
    logic [127:0] ka = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] kb = ~ka;
    int n = 0;
    bit done = 1'b0;
    push_seq(ka);
    bus.key_in = ka;
    bus.load_valid = 1'b1;
    tick();
    bus.key_in = kb;
    while (!done && n < 600) begin
      bus.rk_ready = 1'($urandom_range(0, 1));
      if (bus.rk_valid && bus.rk_last && bus.rk_ready) begin
        tick();
        vectors++;
        if (bus.load_ready !== 1'b1 || bus.rk_valid !== 1'b0) begin
          miscompares++; $display("FAIL ign_handoff: got load_ready=%b valid=%b, required 1/0", bus.load_ready, bus.rk_valid);
        end
        bus.load_valid = 1'b0;
        done = 1'b1;
      end else begin
        vectors++;
        if (bus.load_ready !== 1'b0) begin miscompares++; $display("FAIL ign_load_ready: got %b, required 0", bus.load_ready); end
        tick();
        n++;
      end
    end
    vectors++;
    if (!done || sb.size() != 0) begin
      miscompares++; $display("FAIL ign_sequence: got done=%b left=%0d, required done=1 left=0", done, sb.size());
    end
    tick();
    vectors++;
    if (bus.rk_valid !== 1'b0 || bus.load_ready !== 1'b1) begin
      miscompares++; $display("FAIL ign_idle: got valid=%b load_ready=%b, required 0/1", bus.rk_valid, bus.load_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bus.rk_ready = 1'b1;
    push_seq(FIPS_KEY);
    load_key(FIPS_KEY);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    vectors++;
    if (bus.load_ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.rk_last !== 1'b0 ||
        bus.round_key !== 128'h0 || bus.rk_idx !== 4'd0) begin
      miscompares++; $display("FAIL rst_fwd: got ready=%b valid=%b last=%b idx=%0d key=%h, required 1/0/0/0/0",
                              bus.load_ready, bus.rk_valid, bus.rk_last, bus.rk_idx, bus.round_key);
    end
    push_seq(FIPS_KEY);
    load_key(FIPS_KEY);
    while (!(bus.rk_valid && bus.rk_idx == 4'd6) && n < 40) begin tick(); n++; end
    vectors++;
    if (n >= 40) begin miscompares++; $display("FAIL rst_emit_reach: got idx=%0d, required idx=6", bus.rk_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    vectors++;
    if (bus.load_ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.rk_last !== 1'b0 ||
        bus.round_key !== 128'h0 || bus.rk_idx !== 4'd0) begin
      miscompares++; $display("FAIL rst_emit: got ready=%b valid=%b last=%b idx=%0d key=%h, required 1/0/0/0/0",
                              bus.load_ready, bus.rk_valid, bus.rk_last, bus.rk_idx, bus.round_key);
    end
    push_seq(FIPS_KEY);
    load_key(FIPS_KEY);
    wait_drain("rst_reload");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int lat = 0;
    bus.rk_ready = 1'b1;
    push_seq(FIPS_KEY);
    push_seq(128'h0);
    bus.key_in = FIPS_KEY;
    bus.load_valid = 1'b1;
    tick();
    bus.key_in = 128'h0;
    while (!bus.load_ready && n < 100) begin tick(); n++; end
    tick();
    bus.load_valid = 1'b0;
    while (!bus.rk_valid && lat < 30) begin tick(); lat++; end
    vectors++;
    if (lat != 10) begin miscompares++; $display("FAIL b2b_latency: got %0d cycles, required 10", lat); end
    vectors++;
    if (bus.round_key !== ZERO_R10 || bus.rk_idx !== 4'd10) begin
      miscompares++; $display("FAIL b2b_r10: got idx=%0d key=%h, required idx=10 key=%h", bus.rk_idx, bus.round_key, ZERO_R10);
    end
    wait_drain("b2b");
  endtask

`ifdef AES_INV_KEY_PRELOAD_EN
  task automatic test_preload();
    int n = 0;
    bus.rk_ready = 1'b1;
    push_seq(FIPS_KEY);
    bus.load_is_last = 1'b1;
    load_key(FIPS_R10);
    bus.load_is_last = 1'b0;
    vectors++;
    if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd10 || bus.round_key !== FIPS_R10) begin
      miscompares++; $display("FAIL pre_first: got valid=%b idx=%0d key=%h, required 1/10/%h",
                              bus.rk_valid, bus.rk_idx, bus.round_key, FIPS_R10);
    end
    while (bus.rk_idx !== 4'd0 && n < 20) begin tick(); n++; end
    vectors++;
    if (bus.round_key !== FIPS_KEY || bus.rk_last !== 1'b1) begin
      miscompares++; $display("FAIL pre_r0: got last=%b key=%h, required 1/%h", bus.rk_last, bus.round_key, FIPS_KEY);
    end
    wait_drain("preload");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    init_model();
    test_reset();
    test_fips();
    test_backpressure();
    test_load_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef AES_INV_KEY_PRELOAD_EN
    test_preload();
`endif
    repeat (3) tick();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL final_sb: got %0d keys left, required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
